// File: rtl/exh_sweep_gen_if.sv
// Bundle of the sweep generator's control, stimulus and response signals.
// The slave modport is the generator's view. The master modport is the view
// of whatever drives start/mode/abort and returns the DUT response.
interface exh_sweep_gen_if #(
  parameter int N    = 4,
  parameter int YW   = 1,
  parameter int SIGW = 16
);
  logic            start;
  logic            mode;
  logic            abort;
  logic [YW-1:0]   dut_y;
  logic [N-1:0]    stim;
  logic            sample;
  logic            busy;
  logic            done;
  logic [N:0]      vec_cnt;
  logic [SIGW-1:0] signature;

  modport master (
    output start, mode, abort, dut_y,
    input  stim, sample, busy, done, vec_cnt, signature
  );

  modport slave (
    input  start, mode, abort, dut_y,
    output stim, sample, busy, done, vec_cnt, signature
  );
endinterface

// File: rtl/exh_sweep_gen.sv
// Exhaustive stimulus sweep generator with MISR response compaction.
// Walks all 2^N input vectors in binary or Gray order. Each vector is held
// for HOLD cycles, and dut_y is folded into the signature on the last cycle
// of each hold.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; stim parked at 0; results held
//   S_DRIVE | driving idx (or its Gray code); sample on last hold cycle
//   S_DONE  | single-cycle completion pulse, then back to S_IDLE
module exh_sweep_gen #(
  parameter int              N    = 4,
  parameter int              HOLD = 10,
  parameter int              YW   = 1,
  parameter int              SIGW = 16,
  parameter logic [SIGW-1:0] POLY = 16'h1021
) (
  input logic            clk,
  input logic            rst_n,
  exh_sweep_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The hold counter needs at least one bit, even when HOLD == 1.
  localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]   IDX_LAST  = '1;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            mode_q, mode_d;
  logic [N-1:0]    stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N:0]      vec_cnt_q, vec_cnt_d;
  logic [SIGW-1:0] sig_q, sig_d;

  logic            sample_w;
  logic [N-1:0]    idx_nxt;
  logic [SIGW-1:0] misr_nxt;

  function automatic logic [N-1:0] order_of(input logic [N-1:0] v, input logic gray);
    return gray ? (v ^ (v >> 1)) : v;
  endfunction

  // The strobe comes straight from registered state. It is high on the
  // last cycle of each hold window.
  assign sample_w = (state_q == S_DRIVE) && (hold_cnt_q == HOLD_LAST);
  assign idx_nxt  = idx_q + 1'b1;
  assign misr_nxt = {sig_q[SIGW-2:0], 1'b0}
                  ^ (sig_q[SIGW-1] ? POLY : {SIGW{1'b0}})
                  ^ SIGW'(bus.dut_y);

  // Compute the next state and next register values. abort takes priority over sample.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    vec_cnt_d  = vec_cnt_q;
    sig_d      = sig_q;

    case (state_q)
      S_IDLE: begin
        stim_d = '0;
        busy_d = 1'b0;
        // When start and abort are both high, start is ignored.
        if (bus.start && !bus.abort) begin
          state_d    = S_DRIVE;
          idx_d      = '0;
          hold_cnt_d = '0;
          mode_d     = bus.mode;
          stim_d     = '0;
          busy_d     = 1'b1;
          vec_cnt_d  = '0;
          sig_d      = '0;
        end
      end

      S_DRIVE: begin
        if (bus.abort) begin
          // Keep the partial signature and count. Drop the vector in flight.
          state_d    = S_IDLE;
          idx_d      = '0;
          hold_cnt_d = '0;
          stim_d     = '0;
          busy_d     = 1'b0;
        end else if (sample_w) begin
          sig_d      = misr_nxt;
          vec_cnt_d  = vec_cnt_q + 1'b1;
          hold_cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            // idx does not wrap. Leave it for the next start to clear.
            state_d = S_DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            stim_d = order_of(idx_nxt, mode_q);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        stim_d  = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        idx_d      = '0;
        hold_cnt_d = '0;
        stim_d     = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Hold all state in registers. Reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      mode_q     <= 1'b0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vec_cnt_q  <= '0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vec_cnt_q  <= vec_cnt_d;
      sig_q      <= sig_d;
    end
  end

  assign bus.stim      = stim_q;
  assign bus.sample    = sample_w;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vec_cnt   = vec_cnt_q;
  assign bus.signature = sig_q;

endmodule

// File: tb/tb_exh_sweep_gen.sv
// Directed bench for exh_sweep_gen. It drives three configurations from one clock.
//   u0: N=2 HOLD=1  -- short binary sweep with dut_y tied high
//   u1: N=4 HOLD=10 -- Gray sweep, stim[0] feedback, and reset mid-sweep
//   u2: N=4 HOLD=2  -- abort that coincides with a sample
module tb_exh_sweep_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exh_sweep_gen_if #(.N(2), .YW(1), .SIGW(16)) if0 ();
  exh_sweep_gen_if #(.N(4), .YW(1), .SIGW(16)) if1 ();
  exh_sweep_gen_if #(.N(4), .YW(1), .SIGW(16)) if2 ();

  exh_sweep_gen #(.N(2), .HOLD(1),  .YW(1), .SIGW(16), .POLY(16'h1021))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  exh_sweep_gen #(.N(4), .HOLD(10), .YW(1), .SIGW(16), .POLY(16'h1021))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  exh_sweep_gen #(.N(4), .HOLD(2),  .YW(1), .SIGW(16), .POLY(16'h1021))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic y1_follow;
  logic y1_const;
  assign if0.dut_y = 1'b1;
  assign if2.dut_y = 1'b1;
  assign if1.dut_y = y1_follow ? if1.stim[0] : y1_const;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    y1_follow = 1'b0;
    y1_const  = 1'b0;
    if0.start = 1'b0; if0.mode = 1'b0; if0.abort = 1'b0;
    if1.start = 1'b0; if1.mode = 1'b0; if1.abort = 1'b0;
    if2.start = 1'b0; if2.mode = 1'b0; if2.abort = 1'b0;

    // Reset state
    #2;
    check("rst_stim",   if1.stim, 0);
    check("rst_sample", if1.sample, 0);
    check("rst_busy",   if1.busy, 0);
    check("rst_done",   if1.done, 0);
    check("rst_vec",    if1.vec_cnt, 0);
    check("rst_sig",    if1.signature, 0);
    #5 rst_n = 1'b1;
    tick();
    check("idle_busy0", if0.busy, 0);

    // u0: binary sweep of 4 vectors with dut_y=1. done arrives 5 edges after start.
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("u0_stim",   if0.stim, k);
      check("u0_sample", if0.sample, 1);
      check("u0_busy",   if0.busy, 1);
      tick();
    end
    check("u0_done",  if0.done, 1);
    check("u0_busyd", if0.busy, 0);
    check("u0_vec",   if0.vec_cnt, 4);
    check("u0_sig",   if0.signature, 16'h000F);
    if0.start = 1'b1;                 // start during DONE is ignored
    tick();
    if0.start = 1'b0;
    check("u0_done_clr",  if0.done, 0);
    check("u0_idle_busy", if0.busy, 0);
    check("u0_idle_stim", if0.stim, 0);
    check("u0_idle_sig",  if0.signature, 16'h000F);

    // u1: Gray sweep with dut_y=0. The mode toggle mid-sweep must be ignored.
    if1.mode  = 1'b1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    if1.mode  = 1'b0;
    for (int v = 0; v < 16; v++) begin
      for (int h = 0; h < 10; h++) begin
        check("u1_gray_stim",   if1.stim, v ^ (v >> 1));
        check("u1_gray_sample", if1.sample, (h == 9) ? 1 : 0);
        tick();
      end
    end
    check("u1_gray_done", if1.done, 1);
    check("u1_gray_busy", if1.busy, 0);
    check("u1_gray_vec",  if1.vec_cnt, 16);
    check("u1_gray_sig",  if1.signature, 0);
    tick();
    check("u1_gray_done_clr", if1.done, 0);
    check("u1_gray_idle_stim", if1.stim, 0);

    // u1: binary sweep with dut_y = stim[0] (0,1,0,1,...). The signature is 16'h5555.
    y1_follow = 1'b1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (159) tick();
    check("u1_fb_early", if1.done, 0);
    tick();
    check("u1_fb_done", if1.done, 1);
    check("u1_fb_vec",  if1.vec_cnt, 16);
    check("u1_fb_sig",  if1.signature, 16'h5555);
    repeat (3) tick();
    check("u1_fb_hold_sig", if1.signature, 16'h5555);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("u1_fb2_sig_clr", if1.signature, 0);
    repeat (160) tick();
    check("u1_fb2_done", if1.done, 1);
    check("u1_fb2_sig",  if1.signature, 16'h5555);
    tick();

    // u2: abort in the same cycle as the 5th sample.
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    repeat (9) tick();
    check("u2_pre_sample", if2.sample, 1);
    check("u2_pre_vec",    if2.vec_cnt, 4);
    check("u2_pre_stim",   if2.stim, 4);
    if2.abort = 1'b1;
    tick();
    if2.abort = 1'b0;
    check("u2_ab_busy", if2.busy, 0);
    check("u2_ab_done", if2.done, 0);
    check("u2_ab_vec",  if2.vec_cnt, 4);
    check("u2_ab_sig",  if2.signature, 16'h000F);
    check("u2_ab_stim", if2.stim, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("u2_ab_nodone", if2.done, 0);
    end
    if2.abort = 1'b1;                 // abort in IDLE has no effect
    tick();
    check("u2_idle_abort_vec", if2.vec_cnt, 4);
    if2.start = 1'b1;                 // start together with abort is ignored
    tick();
    check("u2_start_abort_busy", if2.busy, 0);
    if2.abort = 1'b0;
    tick();
    if2.start = 1'b0;
    check("u2_restart_busy", if2.busy, 1);
    check("u2_restart_stim", if2.stim, 0);
    check("u2_restart_vec",  if2.vec_cnt, 0);
    tick();
    tick();
    check("u2_restart_stim1", if2.stim, 1);
    if2.abort = 1'b1;
    tick();
    if2.abort = 1'b0;

    // u1: start during busy is ignored, then reset is asserted between edges.
    y1_follow = 1'b0;
    y1_const  = 1'b1;
    if1.mode  = 1'b1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    repeat (12) tick();
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("u1_busy_start_vec",  if1.vec_cnt, 1);
    check("u1_busy_start_busy", if1.busy, 1);
    check("u1_busy_start_stim", if1.stim, 1);
    repeat (6) tick();
    check("u1_mid_sample", if1.sample, 1);
    check("u1_mid_sig",    if1.signature, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("u1_arst_stim",   if1.stim, 0);
    check("u1_arst_sample", if1.sample, 0);
    check("u1_arst_busy",   if1.busy, 0);
    check("u1_arst_done",   if1.done, 0);
    check("u1_arst_vec",    if1.vec_cnt, 0);
    check("u1_arst_sig",    if1.signature, 0);
    #3 rst_n = 1'b1;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("u1_post_rst_busy", if1.busy, 1);
    check("u1_post_rst_done", if1.done, 0);
    check("u1_post_rst_vec",  if1.vec_cnt, 0);
    if1.abort = 1'b1;
    tick();
    if1.abort = 1'b0;
    check("u1_final_busy", if1.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/exh_sweep_gen.md
EXH_SWEEP_GEN -- requirements
Module: exh_sweep_gen

Interface
REQ-001 Parameter N, default 4: stimulus width; the sweep covers all 2^N input vectors.
REQ-002 Parameter HOLD, default 10: clock cycles each vector is held (HOLD >= 1).
REQ-003 Parameter YW, default 1: width of the DUT response bus.
REQ-004 Parameter SIGW, default 16: signature width (SIGW > YW).
REQ-005 Parameter POLY, default 16'h1021: MISR feedback polynomial, SIGW bits.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  begin a sweep; sampled only in IDLE.
REQ-009 mode  input  1  0 = binary order, 1 = Gray order; latched at start.
REQ-010 abort  input  1  terminate a running sweep.
REQ-011 dut_y  input  YW  DUT response to the current stim.
REQ-012 stim  output  N  vector driven to the DUT.
REQ-013 sample  output  1  one-cycle strobe; dut_y is captured this cycle.
REQ-014 busy  output  1  high while a sweep is running.
REQ-015 done  output  1  one-cycle pulse on sweep completion.
REQ-016 vec_cnt  output  N+1  number of vectors sampled in the current or last sweep.
REQ-017 signature  output  SIGW  MISR compaction of all sampled dut_y.

Function
REQ-018 FSM states: IDLE, DRIVE, DONE; all outputs registered.
REQ-019 IDLE with start=1: next edge enters DRIVE with idx=0, hold_cnt=0, vec_cnt=0, signature=0, mode latched.
REQ-020 IDLE with start=0: state, stim, vec_cnt and signature hold.
REQ-021 In DRIVE, stim = idx in binary mode and idx ^ (idx>>1) in Gray mode; stim is stable for exactly HOLD cycles per vector.
REQ-022 In DRIVE, hold_cnt increments each cycle; sample=1 when hold_cnt==HOLD-1 (the last hold cycle); sample is combinational from registered state.
REQ-023 On an edge where sample=1: signature <= ({signature[SIGW-2:0],1'b0} ^ (signature[SIGW-1] ? POLY : 0)) ^ zero-extended dut_y; vec_cnt increments; hold_cnt clears.
REQ-024 On a sample edge with idx < 2^N-1: idx increments; with idx == 2^N-1: go to DONE, with no idx wrap.
REQ-025 DONE lasts one cycle with done=1, then IDLE; stim returns to 0 in IDLE.
REQ-026 busy=1 in DRIVE only.
REQ-027 Latency: the start edge to the done-high cycle spans 2^N*HOLD+1 edges.
REQ-028 start while busy or in DONE is ignored, and mode changes mid-sweep are ignored.
REQ-029 abort=1 in DRIVE: the next edge enters IDLE, done is not asserted, and signature/vec_cnt retain their partial values.
REQ-030 abort and sample in the same cycle: abort wins; that sample is not compacted.
REQ-031 abort in IDLE or DONE has no effect; start and abort both high in IDLE means start is ignored.

Reset
REQ-032 rst_n=0 forces, immediately and regardless of clk: state IDLE, stim=0, sample=0, busy=0, done=0, vec_cnt=0, signature=0, idx=0, hold_cnt=0.
REQ-033 Reset asserted mid-sweep discards the sweep; no done pulse follows.
REQ-034 After rst_n rises, the first start is honoured on the next rising edge.

Verification
REQ-035 N=2, HOLD=1, mode=0, dut_y=1 tied, pulse start -> stim 0,1,2,3 on successive cycles; done 5 edges after start; vec_cnt=4; signature=16'h000F.
REQ-036 N=4, HOLD=10, mode=1, dut_y=0 -> stim follows Gray order 0,1,3,2,6,...,8 with each value held 10 cycles; done after 161 edges; vec_cnt=16; signature=0.
REQ-037 N=4, HOLD=10, dut_y=stim[0] -> signature matches the bench MISR model; a second start reproduces an identical signature.
REQ-038 N=4, HOLD=2: abort in the same cycle as the 5th sample -> IDLE next edge; vec_cnt=4; no done; a following start restarts from stim=0.
REQ-039 Assert rst_n=0 mid-sweep between edges -> all outputs zero immediately; start during busy is ignored, with vec_cnt unaffected.
